// File: rtl/pmem_pkg.sv
// pmem_pkg: shared constants and types for the burst physical-memory responder.
//   BEAT_W/BEATS/LINE_W  : one 256-bit cacheline is moved as 4 x 64-bit beats
//   OFFSET_BITS          : byte offset within a line (address bits [4:0])
//   pmem_state_t         : responder FSM states
//   pmem_line_t          : one full cacheline
package pmem_pkg;
    localparam int BEAT_W      = 64;
    localparam int BEATS       = 4;
    localparam int LINE_W      = 256;
    localparam int OFFSET_BITS = 5;

    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} pmem_state_t;
    typedef logic [LINE_W-1:0] pmem_line_t;
endpackage

// File: rtl/pmem_line_array.sv
// pmem_line_array: 2^LINE_IDX_BITS x 256-bit line store, block-RAM style.
//   clk              : clock
//   rd_en/rd_idx     : synchronous line read; rd_line updates on the next edge
//                      and holds its value while rd_en is low
//   rd_line          : registered read data
//   wr_en/wr_idx     : synchronous full-line write
//   wr_line          : line to write
// Contents are not reset.
module pmem_line_array
    import pmem_pkg::*;
#(
    parameter int LINE_IDX_BITS = 10
) (
    input  logic                     clk,
    input  logic                     rd_en,
    input  logic [LINE_IDX_BITS-1:0] rd_idx,
    output logic [LINE_W-1:0]        rd_line,
    input  logic                     wr_en,
    input  logic [LINE_IDX_BITS-1:0] wr_idx,
    input  logic [LINE_W-1:0]        wr_line
);
    logic [LINE_W-1:0] mem [2**LINE_IDX_BITS];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_line;
        if (rd_en) rd_line <= mem[rd_idx];
    end
endmodule

// File: rtl/pmem_burst_responder.sv
// pmem_burst_responder: fixed-latency physical memory answering 4x64-bit bursts.
//   clk, rst         : clock, synchronous active-high reset
//   pmem_read/write  : burst request, held by the initiator until the last beat
//   pmem_address     : line address, [4:0] ignored, upper bits alias
//   pmem_wdata       : write beat, sampled while pmem_resp is high
//   pmem_rdata       : read beat, zero whenever pmem_resp is low
//   pmem_resp        : high for the 4 beat cycles of a burst
//   proto_err        : sticky protocol-violation flag
// Optional build macro PMEM_PROTO_CHECK_EN enables the protocol checker;
// without it proto_err is tied low.
module pmem_burst_responder
    import pmem_pkg::*;
#(
    parameter int LINE_IDX_BITS = 10,
    parameter int LATENCY       = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pmem_read,
    input  logic        pmem_write,
    input  logic [31:0] pmem_address,
    input  logic [63:0] pmem_wdata,
    output logic [63:0] pmem_rdata,
    output logic        pmem_resp,
    output logic        proto_err
);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    pmem_state_t              state, nstate;
    logic                     op_rd;
    logic [LINE_IDX_BITS-1:0] idx;
    logic [CNT_W-1:0]         lat_cnt;
    logic [1:0]               beat;
    logic [BEAT_W*(BEATS-1)-1:0] wbuf;   // beats 0..2; beat 3 goes straight to the array
    logic                     req_any, req_held;
    logic                     rd_en, wr_en;
    logic [LINE_W-1:0]        rd_line;

    assign req_any  = pmem_read | pmem_write;
    // The request that keeps the current burst alive is the one that was latched.
    assign req_held = op_rd ? pmem_read : pmem_write;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        nstate = state;
        case (state)
            IDLE:  if (req_any) nstate = WAIT;
            WAIT:  if (!req_held) nstate = IDLE;
                   else if (lat_cnt == '0) nstate = BURST;
            BURST: if (!req_held) nstate = IDLE;
                   else if (beat == 2'd3) nstate = DONE;
            DONE:  nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // resp is qualified by the held request so an aborted beat never shows.
    always_comb begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        case (state)
            WAIT:  rd_en = op_rd && (lat_cnt == '0);
            BURST: begin
                pmem_resp = req_held;
                if (op_rd && req_held) pmem_rdata = rd_line[{beat, 6'd0} +: BEAT_W];
                wr_en = !op_rd && pmem_write && (beat == 2'd3);
            end
            default: ;
        endcase
    end

    // ---------------- datapath: request latch and counters ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            op_rd   <= 1'b0;
            idx     <= '0;
            lat_cnt <= '0;
            beat    <= '0;
        end else begin
            case (state)
                IDLE: if (req_any) begin
                    op_rd   <= pmem_read;   // read wins when both are high
                    idx     <= pmem_address[LINE_IDX_BITS+OFFSET_BITS-1:OFFSET_BITS];
                    lat_cnt <= CNT_W'(LATENCY - 1);
                    beat    <= '0;
                end
                WAIT:    if (lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
                BURST:   beat <= beat + 2'd1;
                default: beat <= '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == BURST && !op_rd && beat != 2'd3)
            wbuf[{beat, 6'd0} +: BEAT_W] <= pmem_wdata;
    end

    pmem_line_array #(.LINE_IDX_BITS(LINE_IDX_BITS)) u_array (
        .clk     (clk),
        .rd_en   (rd_en),
        .rd_idx  (idx),
        .rd_line (rd_line),
        .wr_en   (wr_en),
        .wr_idx  (idx),
        .wr_line ({pmem_wdata, wbuf})
    );

`ifdef PMEM_PROTO_CHECK_EN
    logic [31-OFFSET_BITS:0] addr_q;
    logic                    err_q;
    logic                    viol;

    always_comb begin
        viol = 1'b0;
        case (state)
            IDLE:        viol = pmem_read && pmem_write;
            WAIT, BURST: viol = (op_rd ? (!pmem_read || pmem_write)
                                       : (!pmem_write || pmem_read))
                             || (pmem_address[31:OFFSET_BITS] != addr_q);
            default:     viol = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            if (state == IDLE) addr_q <= pmem_address[31:OFFSET_BITS];
            if (viol)          err_q  <= 1'b1;
        end
    end

    assign proto_err = err_q;
`else
    logic unused_addr;
    assign unused_addr = ^{pmem_address[31:LINE_IDX_BITS+OFFSET_BITS],
                           pmem_address[OFFSET_BITS-1:0]};
    assign proto_err   = 1'b0;
`endif
endmodule

// File: tb/tb_pmem_burst_responder.sv
module tb_pmem_burst_responder;
    localparam int LAT = 10;
`ifdef PMEM_PROTO_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pmem_read, pmem_write;
    logic [31:0] pmem_address;
    logic [63:0] pmem_wdata, pmem_rdata;
    logic        pmem_resp, proto_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct { int cyc; logic [63:0] data; } exp_t;
    exp_t q[$];

    pmem_burst_responder #(.LINE_IDX_BITS(10), .LATENCY(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Hand-computed lines
    localparam logic [255:0] LINE_A = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] LINE_B = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                                       64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
    localparam logic [255:0] LINE_C = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                       64'hBBBB_BBBB_BBBB_BBBB, 64'h9999_9999_9999_9999};

    // Monitor: every resp beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (pmem_resp) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL extra_resp cyc=%0d rdata=%h expected no beat", cyc, pmem_rdata);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.cyc != cyc || e.data != pmem_rdata) begin
                    errors++;
                    $display("FAIL beat cyc=%0d rdata=%h expected cyc=%0d rdata=%h",
                             cyc, pmem_rdata, e.cyc, e.data);
                end
            end
        end else if (!rst) begin
            checks++;
            if (pmem_rdata != 64'd0) begin
                errors++;
                $display("FAIL rdata_idle cyc=%0d rdata=%h expected 0", cyc, pmem_rdata);
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    // One burst. drop_after>=0: drop the request in the cycle after that beat.
    // keep: leave the request asserted through DONE. held: request was already
    // asserted across the previous DONE, so it is accepted one cycle later.
    task automatic burst(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [255:0] wl, input logic [255:0] rl,
                         input int drop_after, input bit keep, input bit held);
        int t0, nb;
        @(posedge clk); #1;
        pmem_read = rd; pmem_write = wr; pmem_address = addr;
        t0 = held ? cyc + 1 : cyc;
        nb = (drop_after < 0) ? 4 : drop_after + 1;
        for (int i = 0; i < nb; i++)
            q.push_back('{t0 + LAT + 1 + i, rd ? rl[64*i +: 64] : 64'd0});
        while (cyc < t0 + LAT + nb) begin
            @(posedge clk); #1;
            if (cyc >= t0 + LAT + 1 && cyc <= t0 + LAT + 4)
                pmem_wdata = wl[64*(cyc - t0 - LAT - 1) +: 64];
            else
                pmem_wdata = '0;
        end
        if (drop_after >= 0 || !keep) begin
            @(posedge clk); #1;
            pmem_read = 1'b0; pmem_write = 1'b0; pmem_wdata = '0;
        end
    endtask

    initial begin
        rst = 1'b1; pmem_read = 1'b0; pmem_write = 1'b0;
        pmem_address = '0; pmem_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_resp", {63'd0, pmem_resp}, 64'd0);
        chk("reset_rdata", pmem_rdata, 64'd0);
        chk("reset_proto_err", {63'd0, proto_err}, 64'd0);

        // write then read back, offset bits ignored
        burst(0, 1, 32'h0000_0100, LINE_A, '0, -1, 0, 0);
        burst(1, 0, 32'h0000_0100, '0, LINE_A, -1, 0, 0);
        burst(1, 0, 32'h0000_011C, '0, LINE_A, -1, 0, 0);
        // aliasing write, then read at the base address
        burst(0, 1, 32'h0000_8100, LINE_B, '0, -1, 0, 0);
        burst(1, 0, 32'h0000_0100, '0, LINE_B, -1, 0, 0);
        @(negedge clk);
        chk("proto_err_clean", {63'd0, proto_err}, 64'd0);

        // write aborted after beat 1: no commit
        burst(0, 1, 32'h0000_0100, LINE_C, '0, 1, 0, 0);
        @(negedge clk);
        chk("resp_after_drop", {63'd0, pmem_resp}, 64'd0);
        chk("proto_err_drop", {63'd0, proto_err}, {63'd0, ERR_EN});
        burst(1, 0, 32'h0000_0100, '0, LINE_B, -1, 0, 0);

        // reset during WAIT of a read
        @(posedge clk); #1;
        pmem_read = 1'b1; pmem_address = 32'h0000_0100;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1; pmem_read = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("proto_err_after_rst", {63'd0, proto_err}, 64'd0);
        repeat (LAT + 3) @(posedge clk);
        burst(1, 0, 32'h0000_0100, '0, LINE_B, -1, 0, 0);

        // read and write both high: read is served
        burst(1, 1, 32'h0000_0100, LINE_C, LINE_B, -1, 0, 0);
        @(negedge clk);
        chk("proto_err_both", {63'd0, proto_err}, {63'd0, ERR_EN});

        // back-to-back reads with the request held across DONE
        burst(1, 0, 32'h0000_0100, '0, LINE_B, -1, 1, 0);
        burst(1, 0, 32'h0000_0100, '0, LINE_B, -1, 0, 1);
        repeat (4) @(negedge clk);
        chk("proto_err_sticky", {63'd0, proto_err}, {63'd0, ERR_EN});
        chk("scoreboard_empty", 64'(q.size()), 64'd0);

        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("proto_err_cleared", {63'd0, proto_err}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
